// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU task dispatcher, its arbiter and the core array.
package gpu_pkg;

  localparam int INS_W    = 16;
  localparam int PROG_LEN = 16;
  localparam int WIDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } disp_state_t;

  // Opcode occupies the top nibble of every instruction word
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_RET = 4'hF;

  // Population count over up to 16 per-core flags
  function automatic logic [4:0] count_ones16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Round-robin pick: first set bit of avail at or after ptr, wrapping around.
module gpu_rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] avail,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     grant,
  output logic                 grant_valid
);

  logic [2*NUM_CORES-1:0] avail2;
  logic [NUM_CORES-1:0]   rot;
  logic [PTR_W-1:0]       off;
  logic [PTR_W:0]         sum;

  // Doubling the vector lets a plain shift implement the wrap-around rotation
  assign avail2 = {avail, avail};
  assign rot    = NUM_CORES'(avail2 >> ptr);

  // Lowest set bit of the rotated vector is the offset from the pointer
  always_comb begin
    off         = '0;
    grant_valid = |rot;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot[i]) off = PTR_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_CORES)) sum = sum - (PTR_W+1)'(NUM_CORES);
    grant = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/gpu_task_dispatcher.sv
// Streams one buffered 16-word program into idle cores, round-robin, and
// retires tasks when the loaded cores raise ready.
module gpu_task_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [3:0]           prog_addr,
  input  logic [INS_W-1:0]     prog_data,
  input  logic                 start,
  input  logic [7:0]           task_count,
  input  logic [NUM_CORES-1:0] rtr,
  input  logic [NUM_CORES-1:0] ready,
  output logic [NUM_CORES-1:0] val_ins,
  output logic [INS_W-1:0]     instruction,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           tasks_done
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  disp_state_t          state_reg, state_next;
  logic [INS_W-1:0]     prog_buf [PROG_LEN];
  logic [7:0]           left_reg, out_reg, tasks_done_reg;
  logic [NUM_CORES-1:0] core_busy_reg;
  logic [PTR_W-1:0]     rr_ptr_reg, sel_reg;
  logic [WIDX_W-1:0]    widx_reg;

  logic [NUM_CORES-1:0] avail, retire_vec, sel_onehot;
  logic [PTR_W-1:0]     grant;
  logic                 grant_valid, dispatch_ok, xfer, last_xfer;
  logic [4:0]           retire_cnt;
  logic [8:0]           td_sum;

  assign avail       = rtr & ~core_busy_reg;
  assign dispatch_ok = (state_reg == ARB) && (left_reg != 8'd0) && grant_valid;
  assign xfer        = (state_reg == SEND) && rtr[sel_reg];
  assign last_xfer   = xfer && (widx_reg == WIDX_W'(PROG_LEN - 1));
  assign retire_vec  = (state_reg != IDLE) ? (core_busy_reg & ready) : '0;
  assign retire_cnt  = count_ones16(16'(retire_vec));
  assign td_sum      = {1'b0, tasks_done_reg} + 9'(retire_cnt);
  assign tasks_done  = tasks_done_reg;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_sel
      assign sel_onehot[gi] = (sel_reg == PTR_W'(gi));
    end
  endgenerate

  gpu_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_arb (
    .avail       (avail),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Program buffer: host writes only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we && (state_reg == IDLE)) prog_buf[prog_addr] <= prog_data;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state; dispatch waits in ARB once every task is out
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = ARB;
      ARB: begin
        if ((left_reg == 8'd0) && (out_reg == 8'd0)) state_next = DONE;
        else if (dispatch_ok)                        state_next = SEND;
      end
      SEND:    if (last_xfer) state_next = ARB;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the bus is driven only while loading a core
  always_comb begin
    val_ins     = '0;
    instruction = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      ARB: busy = 1'b1;
      SEND: begin
        busy        = 1'b1;
        val_ins     = sel_onehot;
        instruction = prog_buf[widx_reg];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Task bookkeeping: dispatch and retire in the same cycle both apply
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_reg       <= '0;
      out_reg        <= '0;
      tasks_done_reg <= '0;
      core_busy_reg  <= '0;
      rr_ptr_reg     <= '0;
      sel_reg        <= '0;
      widx_reg       <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        left_reg       <= task_count;
        out_reg        <= '0;
        tasks_done_reg <= '0;
      end else begin
        out_reg        <= out_reg + 8'(last_xfer) - 8'(retire_cnt);
        tasks_done_reg <= td_sum[8] ? 8'hFF : td_sum[7:0];
        core_busy_reg  <= (core_busy_reg & ~retire_vec) |
                          (last_xfer ? sel_onehot : '0);
        if (last_xfer) left_reg <= left_reg - 8'd1;
      end
      if (dispatch_ok) begin
        sel_reg  <= grant;
        widx_reg <= '0;
      end else if (xfer) begin
        widx_reg <= widx_reg + 1'b1;
      end
      if (last_xfer) begin
        rr_ptr_reg <= (sel_reg == PTR_W'(NUM_CORES - 1)) ? '0 : sel_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// Directed bench for gpu_task_dispatcher with 4 cores.
module tb_gpu_task_dispatcher;
  import gpu_pkg::*;

  logic             clk;
  logic             reset;
  logic             prog_we;
  logic [3:0]       prog_addr;
  logic [INS_W-1:0] prog_data;
  logic             start;
  logic [7:0]       task_count;
  logic [3:0]       rtr;
  logic [3:0]       ready;
  logic [3:0]       val_ins;
  logic [INS_W-1:0] instruction;
  logic             busy;
  logic             done;
  logic [7:0]       tasks_done;

  int n_cmp = 0;
  int n_err = 0;

  gpu_task_dispatcher #(.NUM_CORES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .task_count  (task_count),
    .rtr         (rtr),
    .ready       (ready),
    .val_ins     (val_ins),
    .instruction (instruction),
    .busy        (busy),
    .done        (done),
    .tasks_done  (tasks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Program word i is LDI with immediate i, i.e. 16'h1000 + i
  function automatic logic [31:0] prog_word(input int i);
    return 32'h0000_1000 + 32'(i);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_val_ins", 32'(val_ins), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_instr", 32'(instruction), 32'h0);
    @(negedge clk);
    check_eq("rst_tasks_done", 32'(tasks_done), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [7:0] cnt);
    start      = 1'b1;
    task_count = cnt;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'h1);
  endtask

  task automatic wait_val(input int core);
    int n = 0;
    while (val_ins == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("sel_core%0d", core), 32'(val_ins), 32'(4'b0001 << core));
  endtask

  // Follows one load from its first presented word; optionally stalls rtr
  task automatic run_load(input int core, input int stall_word, input int stall_cycles);
    int w = 0;
    int stalled = 0;
    int cyc = 0;
    while (val_ins != 4'b0 && cyc < 60) begin
      check_eq($sformatf("val_c%0d_w%0d", core, w), 32'(val_ins), 32'(4'b0001 << core));
      check_eq($sformatf("ins_c%0d_w%0d", core, w), 32'(instruction), prog_word(w));
      if (w == stall_word && stalled < stall_cycles) begin
        rtr = rtr & ~(4'b0001 << core);
        stalled++;
      end else begin
        rtr = rtr | (4'b0001 << core);
        w++;
      end
      cyc++;
      @(negedge clk);
    end
    check_eq($sformatf("words_c%0d", core), 32'(w), 32'(PROG_LEN));
    check_eq($sformatf("cycles_c%0d", core), 32'(cyc), 32'(PROG_LEN + stall_cycles));
    check_eq("gap_instr", 32'(instruction), 32'h0);
    $display("load core %0d: %0d words in %0d cycles", core, w, cyc);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'h1);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(done), 32'h0);
  endtask

  initial begin
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; task_count = '0; rtr = '0; ready = '0;
    repeat (2) @(negedge clk);
    check_eq("init_val_ins", 32'(val_ins), 32'h0);
    check_eq("init_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Program load
    for (int i = 0; i < PROG_LEN; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = {OP_LDI, 12'(i)};
      @(negedge clk);
    end
    prog_we = 1'b0;
    $display("program loaded: %0d words", PROG_LEN);

    // task_count = 0: ARB then DONE, no load
    do_reset();
    rtr = 4'hF;
    start_run(8'd0);
    check_eq("zero_val_ins_arb", 32'(val_ins), 32'h0);
    check_eq("zero_done_early", 32'(done), 32'h0);
    @(negedge clk);
    check_eq("zero_done", 32'(done), 32'h1);
    check_eq("zero_val_ins", 32'(val_ins), 32'h0);
    check_eq("zero_tasks_done", 32'(tasks_done), 32'h0);
    @(negedge clk);
    check_eq("zero_done_pulse", 32'(done), 32'h0);
    $display("run task_count=0 complete");

    // Single task into core 0, then retire
    do_reset();
    rtr = 4'hF;
    start_run(8'd1);
    check_eq("t1_lat_arb", 32'(val_ins), 32'h0);
    @(negedge clk);
    check_eq("t1_lat_send", 32'(val_ins), 32'h1);
    run_load(0, 99, 0);
    check_eq("t1_gap_val", 32'(val_ins), 32'h0);
    ready = 4'b0001;
    @(negedge clk);
    check_eq("t1_tasks_done", 32'(tasks_done), 32'h1);
    check_eq("t1_no_done_yet", 32'(done), 32'h0);
    ready = 4'b0000;
    wait_done("t1_done");
    check_eq("t1_td_after", 32'(tasks_done), 32'h1);

    // Six tasks round-robin, out-of-order retirement, dual retire
    do_reset();
    rtr = 4'hF;
    start_run(8'd6);
    for (int c = 0; c < 4; c++) begin
      wait_val(c);
      run_load(c, 99, 0);
    end
    repeat (3) @(negedge clk);
    check_eq("t2_all_busy_val", 32'(val_ins), 32'h0);
    check_eq("t2_all_busy_busy", 32'(busy), 32'h1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'hDEAD;
    @(negedge clk);
    prog_we = 1'b0;
    rtr = 4'h0;
    ready = 4'b0100;
    @(negedge clk);
    check_eq("t2_retire_c2", 32'(tasks_done), 32'h1);
    ready = 4'b0001;
    @(negedge clk);
    check_eq("t2_retire_c0", 32'(tasks_done), 32'h2);
    ready = 4'b0000;
    rtr = 4'hF;
    wait_val(0);
    run_load(0, 99, 0);
    wait_val(2);
    run_load(2, 99, 0);
    ready = 4'b1010;
    @(negedge clk);
    check_eq("t2_dual_retire", 32'(tasks_done), 32'h4);
    ready = 4'b0101;
    @(negedge clk);
    check_eq("t2_final_retire", 32'(tasks_done), 32'h6);
    ready = 4'b0000;
    wait_done("t2_done");

    // rtr stall for 3 cycles on word 5
    do_reset();
    rtr = 4'hF;
    start_run(8'd1);
    wait_val(0);
    run_load(0, 5, 3);
    ready = 4'b0001;
    @(negedge clk);
    ready = 4'b0000;
    wait_done("t3_done");

    // Reset in the middle of a load
    do_reset();
    rtr = 4'hF;
    start_run(8'd1);
    wait_val(0);
    repeat (7) @(negedge clk);
    check_eq("t6_word7", 32'(instruction), prog_word(7));
    reset = 1'b0;
    #1;
    check_eq("t6_rst_val_ins", 32'(val_ins), 32'h0);
    check_eq("t6_rst_busy", 32'(busy), 32'h0);
    check_eq("t6_rst_instr", 32'(instruction), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_idle_val", 32'(val_ins), 32'h0);
    start_run(8'd1);
    wait_val(0);
    run_load(0, 99, 0);
    ready = 4'b0001;
    @(negedge clk);
    ready = 4'b0000;
    wait_done("t6_done");
    check_eq("t6_tasks_done", 32'(tasks_done), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_task_dispatcher.md
Name: gpu_task_dispatcher

Overview:
Task-scheduler side of the core instruction-load interface: holds one 16-word program and streams it into idle GPU cores over the rtr/val_ins/instruction handshake. It then watches each core's ready level to retire the task. It launches task_count copies of the program round-robin across NUM_CORES cores, and reports completion to the host controller. It sits between the host/control block and the core array.

Parameters:
NUM_CORES, 4, number of attached cores (1..16)
PROG_LEN, 16, words per program; the core accepts exactly 16
INS_W, 16, instruction width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
prog_we  in  1  host program-buffer write strobe
prog_addr  in  4  program word index
prog_data  in  INS_W  program word
start  in  1  launch request, sampled in IDLE only
task_count  in  8  number of tasks to launch, latched on start
rtr  in  NUM_CORES  per-core ready-to-receive
ready  in  NUM_CORES  per-core task-finished level
val_ins  out  NUM_CORES  one-hot word-valid to the selected core
instruction  out  INS_W  shared instruction bus to all cores
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all tasks have retired
tasks_done  out  8  tasks retired in the current run

Behaviour:
- Reset (reset=0, async) clears all state and outputs: val_ins=0, instruction=0, busy=0, done=0, tasks_done=0, per-core busy flags=0, RR pointer=0, state=IDLE. The program buffer is not reset and keeps its contents.
- Program buffer: 16 x INS_W registers. A write occurs when prog_we=1 and state==IDLE. prog_we in any other state is ignored.
- Word transfer rule: a word moves to core k on a cycle where val_ins[k]=1 and rtr[k]=1.
- Core k is available when rtr[k]=1 and its internal busy flag is 0.
- FSM:
  - IDLE: on start=1, latch left=task_count, out=0, tasks_done=0, set busy=1, and go to ARB.
  - ARB: if left==0 and out==0, go to DONE. Else if any core is available, select the first available index at or after the RR pointer (wrapping), set widx=0, and go to SEND. Else stay in ARB.
  - SEND: val_ins[sel]=1 and instruction=buf[widx]. On transfer, widx increments. On the transfer with widx==PROG_LEN-1: set busy flag[sel]=1, left-1, out+1, RR pointer=sel+1 (mod NUM_CORES), and go to ARB. If rtr[sel]=0, hold the same word with no advance.
  - DONE: done=1 for this cycle, busy=0, go to IDLE.
- Retire logic runs in parallel in every state except IDLE. For each k with busy flag[k]=1 and ready[k]=1: clear flag[k], out-1, and tasks_done+1. Multiple cores retiring in the same cycle are summed. A dispatch and a retire in the same cycle both apply, so out is updated by the net value.
- ready[k]=1 with flag[k]=0 is ignored. The core holds ready high until its next load, and its stale ready is cleared by the first accepted word before its flag is set.
- Outside SEND: val_ins=0 and instruction=0.
- Latency:
  - start edge to first val_ins: 2 cycles.
  - One full load with rtr held high: 16 cycles.
  - Gap between consecutive loads: 1 ARB cycle.
- Edge cases:
  - task_count=0: IDLE, then ARB, then DONE. done pulses 2 cycles after start, with no val_ins.
  - start while not IDLE: ignored.
  - tasks_done saturates at 255.
- Widths: left, out, and tasks_done are 8-bit. out never exceeds NUM_CORES.

Decomposition:
- Shared package gpu_pkg:
  - INS_W and PROG_LEN constants.
  - dispatcher state enum {IDLE, ARB, SEND, DONE}.
  - opcode constants, reused by the core and the bench.
- One sub-module, gpu_rr_arbiter, parameterised by NUM_CORES:
  - inputs: avail vector, pointer.
  - outputs: grant index, grant-valid.
  - purely combinational.
- The remainder (buffer, FSM, retire counters) stays in the top module.

Test Plan:
- Load buf[i]=16'h1000+i, task_count=1, all rtr=1 -> core0 sees val_ins[0] for 16 consecutive cycles carrying 1000..100F. Then raise ready[0] -> tasks_done=1 and done pulses once.
- task_count=6, NUM_CORES=4, cores never retire -> loads go to cores 0,1,2,3 and then FSM stays in ARB. Retire core2, then core0 -> 5th load goes to core0 (first available after pointer 0), 6th to core2.
- rtr[0] dropped for 3 cycles after word 5 -> word 5 held on instruction, 16 transfers total, load completes 3 cycles late.
- task_count=0 -> done pulses 2 cycles after start, val_ins stays 0, tasks_done=0.
- Cores 1 and 3 assert ready in the same cycle -> tasks_done increments by 2. prog_we during the run leaves the buffer unchanged.
- Assert reset low mid-SEND at word 7 -> val_ins=0 immediately, busy=0, state=IDLE, buffer contents preserved. Next start reloads from word 0.
